// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: Mealy hazard/stall/flush controller for a five-stage pipeline.
// Defining PIPE_HAZARD_CTRL_PERF_EN adds the stall_cnt_16/flush_cnt_16 performance counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_LEN  = 2,
  parameter int WDOG_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_exe,
  input  logic        wr_exe,
  input  logic [2:0]  dest_exe_3,
  input  logic [2:0]  src1_dec_3,
  input  logic [2:0]  src2_dec_3,
  input  logic        use1_dec,
  input  logic        use2_dec,
  input  logic        br_mispred,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        redirect,
  output logic        en_f2d,
  output logic        clr_f2d,
  output logic        en_d2e,
  output logic        clr_d2e,
  output logic        en_e2m,
  output logic        en_m2w,
  output logic        mem_timeout,
  output logic [1:0]  state_2
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt_16,
  output logic [15:0] flush_cnt_16
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_LEN - 1);
  localparam logic [7:0] WDOG_LAST    = 8'(WDOG_LIMIT - 1);

  state_e     state_r, state_nx_s, saved_r, saved_nx_s, eff_s;
  logic [2:0] cnt_r, cnt_nx_s;
  logic       pend_r, pend_nx_s;
  logic [7:0] wdog_r, wdog_nx_s;
  logic       timeout_r, wdog_hit_s;
  logic       hazard_s, mispred_s, bubble_s, flush_go_s;
  logic       pc_en_s, redirect_s, en_f2d_s, clr_f2d_s, en_d2e_s, clr_d2e_s, en_e2m_s, en_m2w_s;

  assign hazard_s  = ld_exe & wr_exe &
                     ((use1_dec & (src1_dec_3 == dest_exe_3)) |
                      (use2_dec & (src2_dec_3 == dest_exe_3)));
  assign mispred_s = br_mispred | pend_r;
  // A released stall behaves exactly like the state it interrupted.
  assign eff_s     = (state_r == ST_MEMWAIT) ? saved_r : state_r;

  // Next-state and per-cycle pipeline control, highest priority first.
  always_comb begin
    state_nx_s = ST_RUN;
    saved_nx_s = saved_r;
    cnt_nx_s   = cnt_r;
    pend_nx_s  = pend_r;
    bubble_s   = 1'b0;
    flush_go_s = 1'b0;
    pc_en_s    = 1'b1;
    redirect_s = 1'b0;
    en_f2d_s   = 1'b1;
    clr_f2d_s  = 1'b0;
    en_d2e_s   = 1'b1;
    clr_d2e_s  = 1'b0;
    en_e2m_s   = 1'b1;
    en_m2w_s   = 1'b1;
    if (mem_busy) begin
      pc_en_s    = 1'b0;
      en_f2d_s   = 1'b0;
      en_d2e_s   = 1'b0;
      en_e2m_s   = 1'b0;
      en_m2w_s   = 1'b0;
      state_nx_s = ST_MEMWAIT;
      saved_nx_s = (state_r == ST_MEMWAIT) ? saved_r : state_r;
      pend_nx_s  = pend_r | br_mispred;
    end else if (mispred_s) begin
      redirect_s = 1'b1;
      clr_f2d_s  = 1'b1;
      clr_d2e_s  = 1'b1;
      pend_nx_s  = 1'b0;
      flush_go_s = 1'b1;
      if (FLUSH_LEN > 1) begin
        state_nx_s = ST_FLUSH;
        cnt_nx_s   = FLUSH_RELOAD;
      end else begin
        state_nx_s = ST_RUN;
        cnt_nx_s   = 3'd0;
      end
    end else if (eff_s == ST_FLUSH) begin
      clr_f2d_s  = 1'b1;
      clr_d2e_s  = 1'b1;
      cnt_nx_s   = (cnt_r == 3'd0) ? 3'd0 : cnt_r - 3'd1;
      state_nx_s = (cnt_r > 3'd1) ? ST_FLUSH : ST_RUN;
    end else if (hazard_s) begin
      pc_en_s    = 1'b0;
      en_f2d_s   = 1'b0;
      clr_d2e_s  = 1'b1;
      bubble_s   = 1'b1;
      state_nx_s = ST_RUN;
    end else begin
      state_nx_s = ST_RUN;
    end
  end

  assign wdog_nx_s  = mem_busy ? ((wdog_r == 8'hFF) ? wdog_r : wdog_r + 8'd1) : 8'd0;
  // The flag rises during the limit-th busy cycle itself, not one cycle later.
  assign wdog_hit_s = mem_busy & (wdog_r >= WDOG_LAST);

  // Output drive; reset holds the pipeline cleared and frozen.
  always_comb begin
    if (!rst_n) begin
      pc_en       = 1'b0;
      redirect    = 1'b0;
      en_f2d      = 1'b0;
      clr_f2d     = 1'b1;
      en_d2e      = 1'b0;
      clr_d2e     = 1'b1;
      en_e2m      = 1'b0;
      en_m2w      = 1'b0;
      mem_timeout = 1'b0;
      state_2     = 2'd0;
    end else begin
      pc_en       = pc_en_s;
      redirect    = redirect_s;
      en_f2d      = en_f2d_s;
      clr_f2d     = clr_f2d_s;
      en_d2e      = en_d2e_s;
      clr_d2e     = clr_d2e_s;
      en_e2m      = en_e2m_s;
      en_m2w      = en_m2w_s;
      mem_timeout = timeout_r | wdog_hit_s;
      state_2     = state_r;
    end
  end

  // Controller state, flush count, pending mispredict and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      saved_r   <= ST_RUN;
      cnt_r     <= 3'd0;
      pend_r    <= 1'b0;
      wdog_r    <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      saved_r   <= saved_nx_s;
      cnt_r     <= cnt_nx_s;
      pend_r    <= pend_nx_s;
      wdog_r    <= wdog_nx_s;
      timeout_r <= timeout_r | wdog_hit_s;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_16 <= 16'd0;
      flush_cnt_16 <= 16'd0;
    end else begin
      if ((mem_busy | bubble_s) && (stall_cnt_16 != 16'hFFFF)) begin
        stall_cnt_16 <= stall_cnt_16 + 16'd1;
      end else begin
        stall_cnt_16 <= stall_cnt_16;
      end
      if (flush_go_s && (flush_cnt_16 != 16'hFFFF)) begin
        flush_cnt_16 <= flush_cnt_16 + 16'd1;
      end else begin
        flush_cnt_16 <= flush_cnt_16;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, directed corner sequences and random stimulus
// against a cycle-level behavioural model of pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  localparam int FLUSH_LEN  = 2;
  localparam int WDOG_LIMIT = 255;
  localparam logic [1:0] A_HOLD = 2'd0;
  localparam logic [1:0] A_LOAD = 2'd1;
  localparam logic [1:0] A_CLR  = 2'd2;
  // Observation layout: pc_en, redirect, f2d action, d2e action, en_e2m, en_m2w, mem_timeout, state_2
  localparam logic [10:0] E_NORM = {1'b1, 1'b0, A_LOAD, A_LOAD, 1'b1, 1'b1, 1'b0, 2'd0};
  localparam logic [10:0] E_BUB  = {1'b0, 1'b0, A_HOLD, A_CLR,  1'b1, 1'b1, 1'b0, 2'd0};
  localparam logic [10:0] E_RST  = {1'b0, 1'b0, A_CLR,  A_CLR,  1'b0, 1'b0, 1'b0, 2'd0};

  typedef struct packed {
    logic       ld, wr;
    logic [2:0] dest, s1, s2;
    logic       u1, u2, br, mb;
  } in_t;

  typedef struct {
    string       name;
    in_t         v;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ld_exe, wr_exe, use1_dec, use2_dec, br_mispred, mem_busy;
  logic [2:0] dest_exe_3, src1_dec_3, src2_dec_3;
  logic pc_en, redirect, en_f2d, clr_f2d, en_d2e, clr_d2e, en_e2m, en_m2w, mem_timeout;
  logic [1:0] state_2;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] stall_cnt_16, flush_cnt_16;
`endif

  pipe_hazard_ctrl #(.FLUSH_LEN(FLUSH_LEN), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .ld_exe(ld_exe), .wr_exe(wr_exe), .dest_exe_3(dest_exe_3),
    .src1_dec_3(src1_dec_3), .src2_dec_3(src2_dec_3), .use1_dec(use1_dec), .use2_dec(use2_dec),
    .br_mispred(br_mispred), .mem_busy(mem_busy), .pc_en(pc_en), .redirect(redirect),
    .en_f2d(en_f2d), .clr_f2d(clr_f2d), .en_d2e(en_d2e), .clr_d2e(clr_d2e),
    .en_e2m(en_e2m), .en_m2w(en_m2w), .mem_timeout(mem_timeout), .state_2(state_2)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .stall_cnt_16(stall_cnt_16), .flush_cnt_16(flush_cnt_16)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] last_obs;
  vec_t tbl[9];

  // Reference model: flush cycles still owed, pending mispredict, previous-cycle stall, busy run length.
  int m_flush_left, m_busy_run, m_stalls, m_flushes;
  bit m_pend, m_stalled, m_timeout;

  function automatic in_t mk(input logic ld, wr, input logic [2:0] dest, s1, s2,
                             input logic u1, u2, br, mb);
    in_t v;
    v.ld = ld; v.wr = wr; v.dest = dest; v.s1 = s1; v.s2 = s2;
    v.u1 = u1; v.u2 = u2; v.br = br; v.mb = mb;
    return v;
  endfunction

  function automatic logic [1:0] act(input logic clr, input logic en);
    return clr ? A_CLR : (en ? A_LOAD : A_HOLD);
  endfunction

  function automatic logic [10:0] obs();
    return {pc_en, redirect, act(clr_f2d, en_f2d), act(clr_d2e, en_d2e),
            en_e2m, en_m2w, mem_timeout, state_2};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_flush_left = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0;
    m_pend = 1'b0; m_stalled = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic model_step(input in_t v, output logic [10:0] e);
    logic pc, rd, e2m, m2w, to, hz;
    logic [1:0] af, ad, st;
    hz = v.ld & v.wr & ((v.u1 && v.s1 == v.dest) || (v.u2 && v.s2 == v.dest));
    st = m_stalled ? 2'd2 : ((m_flush_left > 0) ? 2'd1 : 2'd0);
    to = m_timeout || (v.mb && (m_busy_run + 1 >= WDOG_LIMIT));
    pc = 1'b1; rd = 1'b0; af = A_LOAD; ad = A_LOAD; e2m = 1'b1; m2w = 1'b1;
    if (v.mb) begin
      pc = 1'b0; af = A_HOLD; ad = A_HOLD; e2m = 1'b0; m2w = 1'b0;
      m_pend = m_pend | v.br;
      m_busy_run++;
      m_stalled = 1'b1;
      m_stalls++;
    end else begin
      m_busy_run = 0;
      m_stalled  = 1'b0;
      if (v.br || m_pend) begin
        rd = 1'b1; af = A_CLR; ad = A_CLR;
        m_flush_left = FLUSH_LEN - 1;
        m_pend = 1'b0;
        m_flushes++;
      end else if (m_flush_left > 0) begin
        af = A_CLR; ad = A_CLR;
        m_flush_left--;
      end else if (hz) begin
        pc = 1'b0; af = A_HOLD; ad = A_CLR;
        m_stalls++;
      end
    end
    m_timeout = to;
    e = {pc, rd, af, ad, e2m, m2w, to, st};
  endtask

  task automatic drive(input in_t v);
    ld_exe = v.ld; wr_exe = v.wr; dest_exe_3 = v.dest; src1_dec_3 = v.s1; src2_dec_3 = v.s2;
    use1_dec = v.u1; use2_dec = v.u2; br_mispred = v.br; mem_busy = v.mb;
  endtask

  // One cycle: drive just after the edge, compare mid-cycle, advance past the next edge.
  task automatic apply(input string name, input in_t v);
    logic [10:0] e;
    drive(v);
    #2;
    last_obs = obs();
    model_step(v, e);
    chk(name, 16'(last_obs), 16'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t t);
    logic [10:0] e;
    drive(t.v);
    #2;
    last_obs = obs();
    model_step(t.v, e);
    chk(t.name, 16'(last_obs), 16'(t.exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(in_t'(0));
    model_reset();
    @(posedge clk);
    #2;
    chk("reset_outputs", 16'(obs()), 16'(E_RST));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    in_t idle, busy, bb, hz;
    idle = in_t'(0);
    busy = mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    bb   = mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    hz   = mk(1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[0] = '{"lu_src1",      hz,                                                          E_BUB};
    tbl[1] = '{"lu_src2",      mk(1'b1, 1'b1, 3'd5, 3'd1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0), E_BUB};
    tbl[2] = '{"src2_unused",  mk(1'b1, 1'b1, 3'd5, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0), E_NORM};
    tbl[3] = '{"not_load",     mk(1'b0, 1'b1, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0), E_NORM};
    tbl[4] = '{"no_write",     mk(1'b1, 1'b0, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0), E_NORM};
    tbl[5] = '{"reg_differs",  mk(1'b1, 1'b1, 3'd2, 3'd3, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0), E_NORM};
    tbl[6] = '{"reg0_match",   mk(1'b1, 1'b1, 3'd0, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0), E_BUB};
    tbl[7] = '{"reg7_both",    mk(1'b1, 1'b1, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0), E_BUB};
    tbl[8] = '{"all_zero",     idle,                                                        E_NORM};

    do_reset();
    for (int i = 0; i < 9; i++) apply_vec(tbl[i]);

    // Load-use bubble lasts only while the hazard is present.
    apply("lu_cycle", hz);
    chk("lu_pc_en", 16'(last_obs[10]), 16'd0);
    chk("lu_clr_d2e", 16'(last_obs[6:5]), 16'(A_CLR));
    apply("lu_after", idle);
    chk("lu_after_pc_en", 16'(last_obs[10]), 16'd1);

    // Mispredict with a two-cycle flush.
    apply("mp_cycle", bb);
    chk("mp_redirect", 16'(last_obs[9]), 16'd1);
    chk("mp_state0", 16'(last_obs[1:0]), 16'd0);
    apply("mp_flush", mk(1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("mp_flush_clr", 16'(last_obs[8:7]), 16'(A_CLR));
    chk("mp_flush_noredir", 16'(last_obs[9]), 16'd0);
    chk("mp_state1", 16'(last_obs[1:0]), 16'd1);
    apply("mp_done", idle);
    chk("mp_state_back", 16'(last_obs[1:0]), 16'd0);

    // Mispredict arriving during a three-cycle memory stall is deferred.
    for (int i = 0; i < 3; i++) begin
      apply("busy_stall", (i == 0) ? mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1) : busy);
      chk("busy_all_frozen", 16'(last_obs[10:3]), 16'd0);
    end
    apply("busy_release", idle);
    chk("pending_redirect", 16'(last_obs[9]), 16'd1);
    apply("busy_flush", idle);
    apply("busy_done", idle);

    // Watchdog boundary and stickiness.
    for (int i = 1; i <= WDOG_LIMIT; i++) begin
      apply("wdog_busy", busy);
      if (i == WDOG_LIMIT - 1) chk("wdog_before_limit", 16'(last_obs[2]), 16'd0);
      if (i == WDOG_LIMIT)     chk("wdog_at_limit", 16'(last_obs[2]), 16'd1);
    end
    apply("wdog_drop", idle);
    chk("wdog_sticky", 16'(last_obs[2]), 16'd1);
    do_reset();
    apply("wdog_cleared", idle);
    chk("wdog_cleared_flag", 16'(last_obs[2]), 16'd0);

    // Reset mid-FLUSH, then mid-MEMWAIT with a pending mispredict.
    apply("rst_flush_br", bb);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_flush", 16'(obs()), 16'(E_RST));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply("rst_flush_after", idle);
    chk("rst_flush_after_exp", 16'(last_obs), 16'(E_NORM));
    apply("rst_wait_br", mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    rst_n = 1'b0;
    drive(idle);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply("rst_wait_after", idle);
    chk("rst_wait_no_redirect", 16'(last_obs), 16'(E_NORM));

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    do_reset();
    apply("perf_bub1", hz);
    apply("perf_bub2", hz);
    apply("perf_mp", bb);
    apply("perf_idle", idle);
    chk("perf_stall_cnt", stall_cnt_16, 16'd2);
    chk("perf_flush_cnt", flush_cnt_16, 16'd1);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply("random", mk(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
                         3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                         1'($urandom_range(1)), 1'($urandom_range(7) == 0),
                         1'($urandom_range(3) == 0)));
    end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("rand_stall_cnt", stall_cnt_16, 16'(m_stalls));
    chk("rand_flush_cnt", flush_cnt_16, 16'(m_flushes));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_LEN, default 2, cycles clr_f2d is held per mispredict (including the mispredict cycle), legal 1..7.
REQ-002 SHALL have parameter WDOG_LIMIT, default 255, consecutive mem_busy cycles before timeout, legal 1..255.
REQ-003 SHALL have clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ld_exe  in  1  instruction in execute is a load.
REQ-006 SHALL have wr_exe  in  1  instruction in execute writes dest_exe_3.
REQ-007 SHALL have dest_exe_3  in  3  execute destination register.
REQ-008 SHALL have src1_dec_3, src2_dec_3  in  3 each  decode source registers.
REQ-009 SHALL have use1_dec, use2_dec  in  1 each  decode reads src1/src2.
REQ-010 SHALL have br_mispred  in  1  execute-stage branch mispredict, one-cycle pulse.
REQ-011 SHALL have mem_busy  in  1  memory stage not ready.
REQ-012 SHALL have pc_en, redirect  out  1 each  PC load enable; select resolved branch target.
REQ-013 SHALL have en_f2d, clr_f2d, en_d2e, clr_d2e, en_e2m, en_m2w  out  1 each  pipeline register enables/sync clears; clr wins over en.
REQ-014 SHALL have mem_timeout  out  1  sticky watchdog flag.
REQ-015 SHALL have state_2  out  2  FSM state: RUN=0, FLUSH=1, MEMWAIT=2.

Function
REQ-016 SHALL be Mealy: outputs combinational from state, counters and inputs; no register on outputs.
REQ-017 SHALL define hazard = ld_exe & wr_exe & ((use1_dec & src1_dec_3==dest_exe_3) | (use2_dec & src2_dec_3==dest_exe_3)).
REQ-018 SHALL prioritise, per cycle: mem_busy > mispredict (live or pending) > hazard > normal.
REQ-019 SHALL in RUN with no event drive pc_en, all en_* =1, all clr_* =0, redirect=0.
REQ-020 SHALL on hazard in RUN drive pc_en=0, en_f2d=0, clr_d2e=1, en_e2m=en_m2w=1; stay RUN (one bubble per cycle the hazard persists).
REQ-021 SHALL on mispredict drive redirect=1, pc_en=1, clr_f2d=1, clr_d2e=1; if FLUSH_LEN>1 enter FLUSH with remaining count FLUSH_LEN-1, else stay RUN.
REQ-022 SHALL in FLUSH drive clr_f2d=1, clr_d2e=1, pc_en=1, redirect=0, decrement count; return to RUN when count reaches 0; hazard ignored in FLUSH.
REQ-023 SHALL on mem_busy in any state drive pc_en=0, all en_* =0, all clr_* =0, redirect=0, enter/stay MEMWAIT, saving the pre-stall state and flush count.
REQ-024 SHALL latch br_mispred arriving during mem_busy as pending; pending executes (REQ-021) in the first cycle mem_busy=0, then clears.
REQ-025 SHALL in MEMWAIT with mem_busy=0 act as the saved state that cycle (RUN or FLUSH with preserved count) and transition as that state would.
REQ-026 SHALL count consecutive mem_busy cycles (8-bit, clears when mem_busy=0) and set mem_timeout when the count reaches WDOG_LIMIT; mem_timeout holds until reset.
REQ-027 SHALL treat a br_mispred arriving in FLUSH as a new mispredict, reloading the count to FLUSH_LEN-1.

Reset
REQ-028 SHALL while rst_n=0 force state RUN, counters 0, pending 0, mem_timeout 0, and outputs pc_en=0, en_*=0, clr_f2d=clr_d2e=1, redirect=0.
REQ-029 SHALL, when rst_n asserts mid-FLUSH or mid-MEMWAIT, discard the count and pending mispredict; the first cycle after release is RUN.

Configuration
REQ-030 SHALL with PIPE_HAZARD_CTRL_PERF_EN defined add outputs stall_cnt_16 (counts hazard-bubble and MEMWAIT cycles) and flush_cnt_16 (counts executed mispredicts), 16-bit, saturating at 16'hFFFF, reset to 0.
REQ-031 SHALL without PIPE_HAZARD_CTRL_PERF_EN omit both ports and counters; all other behaviour is identical.

Verification
REQ-032 SHALL check load-use: ld_exe=wr_exe=1, dest_exe_3=3, src1_dec_3=3, use1_dec=1 for one cycle -> pc_en=0, en_f2d=0, clr_d2e=1 that cycle only.
REQ-033 SHALL check mispredict, FLUSH_LEN=2: br_mispred pulse -> redirect=1 one cycle, clr_f2d=1 two cycles, state_2 1 then 0.
REQ-034 SHALL check br_mispred during 3-cycle mem_busy -> all en_*=0 for 3 cycles, then redirect=1 in the first free cycle.
REQ-035 SHALL check mem_busy held 255 cycles -> mem_timeout=1 at the 255th cycle, still 1 after mem_busy drops.
REQ-036 SHALL check rst_n pulsed low mid-FLUSH -> state_2=0, clr_f2d=1 during reset; no redirect after release.
REQ-037 SHALL check, with PIPE_HAZARD_CTRL_PERF_EN, 2 bubbles + 1 mispredict -> stall_cnt_16=2, flush_cnt_16=1.
